// File: rtl/vend_coin_arbiter.sv
// Round-robin coin-acceptor arbiter: locks the shared vending machine coin input
// to one acceptor per purchase, releasing it on a sale or an idle timeout.
module vend_coin_arbiter #(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8,
    parameter int CH_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   ch_req,
    input  logic [2*N_CH-1:0] ch_coin,
    output logic [N_CH-1:0]   ch_ack,
    output logic [1:0]        vm_in,
    input  logic              vm_out,
    input  logic [1:0]        vm_change,
    output logic [CH_W-1:0]   owner,
    output logic              busy,
    output logic              reject,
    output logic              done_valid,
    output logic [CH_W-1:0]   done_ch,
    output logic [1:0]        done_change,
    output logic              abandon,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_SETTLE, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [CH_W-1:0]   owner_q, owner_d;
    logic [1:0]        coin_q, coin_d;
    logic [CH_W-1:0]   done_ch_q, done_ch_d;
    logic [1:0]        done_change_q, done_change_d;
    logic              busy_q, busy_d;
    logic              reject_q, reject_d;
    logic              done_valid_q, done_valid_d;
    logic              abandon_q, abandon_d;
    logic [N_CH-1:0]   ack_d;

    logic [CH_W-1:0]   rr_win, scan_idx;
    logic              rr_hit;
    logic [1:0]        win_coin, own_coin;
    logic              own_req;

    function automatic logic [1:0] coin_of(input logic [2*N_CH-1:0] coins,
                                           input logic [CH_W-1:0] ch);
        coin_of = 2'b00;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == CH_W'(k)) coin_of = coins[2*k +: 2];
        end
    endfunction

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
    endfunction

    function automatic logic coin_ok(input logic [1:0] code);
        return code == 2'b01 || code == 2'b10;
    endfunction

    // First requester at or after rr_q, wrapping around the channel ring.
    always_comb begin
        rr_win   = '0;
        rr_hit   = 1'b0;
        scan_idx = rr_q;
        for (int k = 0; k < N_CH; k++) begin
            if (!rr_hit && ch_req[scan_idx]) begin
                rr_hit = 1'b1;
                rr_win = scan_idx;
            end
            scan_idx = next_ch(scan_idx);
        end
    end

    assign win_coin = coin_of(ch_coin, rr_win);
    assign own_coin = coin_of(ch_coin, owner_q);
    assign own_req  = ch_req[owner_q];

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        timer_d       = timer_q;
        owner_d       = owner_q;
        coin_d        = coin_q;
        done_ch_d     = done_ch_q;
        done_change_d = done_change_q;
        reject_d      = 1'b0;
        done_valid_d  = 1'b0;
        abandon_d     = 1'b0;
        ack_d         = '0;
        unique case (state_q)
            S_IDLE: begin
                if (rr_hit) begin
                    ack_d = N_CH'(1) << rr_win;
                    if (coin_ok(win_coin)) begin
                        coin_d  = win_coin;
                        owner_d = rr_win;
                        state_d = S_FEED;
                    end else begin
                        reject_d = 1'b1;
                        rr_d     = next_ch(rr_win);
                    end
                end
            end
            S_FEED: state_d = S_SETTLE;
            S_SETTLE: begin
                if (vm_out) begin
                    done_valid_d  = 1'b1;
                    done_ch_d     = owner_q;
                    done_change_d = vm_change;
                    rr_d          = next_ch(owner_q);
                    owner_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (own_req && coin_ok(own_coin)) begin
                    ack_d   = N_CH'(1) << owner_q;
                    coin_d  = own_coin;
                    state_d = S_FEED;
                end else if (timer_q == CNT_W'(TIMEOUT)) begin
                    // An invalid owner coin pending here stays unacked so that
                    // abandon and reject never pulse together; IDLE rejects it.
                    abandon_d = 1'b1;
                    done_ch_d = owner_q;
                    rr_d      = next_ch(owner_q);
                    owner_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                    if (own_req) begin
                        ack_d    = N_CH'(1) << owner_q;
                        reject_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) || done_valid_d || abandon_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            timer_q       <= '0;
            owner_q       <= '0;
            coin_q        <= 2'b00;
            done_ch_q     <= '0;
            done_change_q <= 2'b00;
            busy_q        <= 1'b0;
            reject_q      <= 1'b0;
            done_valid_q  <= 1'b0;
            abandon_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            timer_q       <= timer_d;
            owner_q       <= owner_d;
            coin_q        <= coin_d;
            done_ch_q     <= done_ch_d;
            done_change_q <= done_change_d;
            busy_q        <= busy_d;
            reject_q      <= reject_d;
            done_valid_q  <= done_valid_d;
            abandon_q     <= abandon_d;
        end
    end

    // Acks are combinational from IDLE, so gate them while reset is held.
    assign ch_ack      = rst ? ack_d : '0;
    assign vm_in       = (state_q == S_FEED) ? coin_q : 2'b00;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign reject      = reject_q;
    assign done_valid  = done_valid_q;
    assign done_ch     = done_ch_q;
    assign done_change = done_change_q;
    assign abandon     = abandon_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Bench for vend_coin_arbiter: coin-acceptor queues and a price-3 vending machine
// drive the DUT; a cycle-timed session model predicts every output.
module tb_vend_coin_arbiter;
  localparam int N  = 4;
  localparam int TO = 4;
  localparam int W2 = 2 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ch_req;
  logic [W2-1:0] ch_coin;
  logic [N-1:0]  ch_ack;
  logic [1:0]    vm_in;
  logic          vm_out;
  logic [1:0]    vm_change;
  logic [1:0]    owner;
  logic          busy;
  logic          reject;
  logic          done_valid;
  logic [1:0]    done_ch;
  logic [1:0]    done_change;
  logic          abandon;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  vend_coin_arbiter #(.N_CH(N), .TIMEOUT(TO), .CNT_W(8), .CH_W(2)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_coin(ch_coin), .ch_ack(ch_ack),
    .vm_in(vm_in), .vm_out(vm_out), .vm_change(vm_change), .owner(owner),
    .busy(busy), .reject(reject), .done_valid(done_valid), .done_ch(done_ch),
    .done_change(done_change), .abandon(abandon), .dbg_state(dbg_state)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // coin acceptor front ends
  logic [1:0] chq [N][$];

  // vending machine: price 3, small = 1, large = 2
  int         vm_credit;
  bit         vm_sale_next;
  logic [1:0] vm_chg_next;
  logic [1:0] vm_seen;
  bit         spur_en;

  // reference model: session lock, time of last valid ack, pending pulses
  int         m_lock;
  int         m_rr;
  int         m_tack;
  int         cyc;
  logic [1:0] m_coin;
  bit         p_rej, p_done, p_ab;
  logic [1:0] m_done_ch, m_change;

  // logs for directed checks
  int         grant_log[$];
  int         abandon_log[$];
  int         ab_cyc;
  int         n_vm_pulse, n_done, n_reject;
  logic [1:0] last_change, last_done_ch;
  logic [N-1:0] last_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] coin_at(input int c);
    logic [W2-1:0] t;
    t = ch_coin >> (2 * c);
    return t[1:0];
  endfunction

  function automatic bit valid_code(input logic [1:0] code);
    return code == 2'b01 || code == 2'b10;
  endfunction

  task automatic apply_inputs();
    logic [N-1:0]  r;
    logic [W2-1:0] c;
    r = '0;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (chq[i].size() > 0) begin
        r = r | (N'(1) << i);
        c = c | (W2'(chq[i][0]) << (2 * i));
      end
    end
    ch_req  = r;
    ch_coin = c;
  endtask

  task automatic push(input int ch, input logic [1:0] code);
    chq[ch].push_back(code);
    apply_inputs();
  endtask

  task automatic model_reset();
    m_lock    = -1;
    m_rr      = 0;
    m_tack    = -1000;
    m_coin    = 2'b00;
    p_rej     = 0;
    p_done    = 0;
    p_ab      = 0;
    m_done_ch = 2'b00;
    m_change  = 2'b00;
  endtask

  task automatic vm_reset();
    vm_credit    = 0;
    vm_sale_next = 0;
    vm_chg_next  = 2'b00;
    vm_seen      = 2'b00;
  endtask

  task automatic model_step();
    int         w;
    int         idx;
    bit         was_free;
    bit         w_valid;
    bit         n_rej, n_done, n_ab;
    logic [1:0] code;
    logic [N-1:0] e_ack;
    w = -1;
    if (m_lock < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && ch_req[idx]) w = idx;
      end
    end else if (cyc >= m_tack + 3 && ch_req[m_lock]) begin
      code = coin_at(m_lock);
      if (valid_code(code) || cyc != m_tack + 3 + TO) w = m_lock;
    end
    e_ack = (w >= 0) ? (N'(1) << w) : '0;
    check("vm_in", 32'(vm_in), (m_lock >= 0 && cyc == m_tack + 1) ? 32'(m_coin) : 32'd0);
    check("ch_ack", 32'(ch_ack), 32'(e_ack));
    check("busy", 32'(busy), 32'(m_lock >= 0 || p_done || p_ab));
    check("owner", 32'(owner), (m_lock >= 0) ? 32'(m_lock) : 32'd0);
    check("reject", 32'(reject), 32'(p_rej));
    check("done_valid", 32'(done_valid), 32'(p_done));
    check("abandon", 32'(abandon), 32'(p_ab));
    check("done_ch", 32'(done_ch), 32'(m_done_ch));
    check("done_change", 32'(done_change), 32'(m_change));

    n_rej = 0; n_done = 0; n_ab = 0;
    was_free = (m_lock < 0);
    w_valid = (w >= 0) && valid_code(coin_at(w));
    if (!was_free && cyc == m_tack + 2 && vm_out) begin
      n_done    = 1;
      m_done_ch = 2'(m_lock);
      m_change  = vm_change;
      m_rr      = (m_lock + 1) % N;
      m_lock    = -1;
    end else if (!was_free && cyc == m_tack + 3 + TO && !w_valid) begin
      n_ab      = 1;
      m_done_ch = 2'(m_lock);
      m_rr      = (m_lock + 1) % N;
      m_lock    = -1;
    end
    if (w >= 0) begin
      if (w_valid) begin
        m_lock = w;
        m_tack = cyc;
        m_coin = coin_at(w);
      end else begin
        n_rej = 1;
        if (was_free) m_rr = (w + 1) % N;
      end
    end
    p_rej = n_rej; p_done = n_done; p_ab = n_ab;
  endtask

  task automatic tick();
    logic [N-1:0] a;
    logic [1:0]   dummy;
    @(negedge clk);
    a = ch_ack;
    last_ack = a;
    if (!rst) begin
      check("rst_ch_ack", 32'(ch_ack), 32'd0);
      check("rst_vm_in", 32'(vm_in), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_pulses", {29'd0, reject, done_valid, abandon}, 32'd0);
      check("rst_done_ch", 32'(done_ch), 32'd0);
      check("rst_done_change", 32'(done_change), 32'd0);
      model_reset();
      vm_reset();
    end else begin
      model_step();
      for (int i = 0; i < N; i++) if (a[i]) grant_log.push_back(i);
      if (vm_in != 2'b00) n_vm_pulse++;
      if (reject) n_reject++;
      if (done_valid) begin
        n_done++;
        last_change  = done_change;
        last_done_ch = done_ch;
      end
      if (abandon) begin
        abandon_log.push_back(int'(done_ch));
        ab_cyc = cyc;
      end
      vm_seen = vm_in;
      if (vm_in == 2'b01) vm_credit += 1;
      if (vm_in == 2'b10) vm_credit += 2;
      if (vm_credit >= 3) begin
        vm_sale_next = 1;
        vm_chg_next  = 2'(vm_credit - 3);
        vm_credit    = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (a[i] && chq[i].size() > 0) dummy = chq[i].pop_front();
    if (vm_seen != 2'b00) begin
      vm_out    = vm_sale_next;
      vm_change = vm_sale_next ? vm_chg_next : 2'($urandom);
    end else begin
      vm_out    = spur_en && ($urandom_range(0, 5) == 0);
      vm_change = 2'($urandom);
    end
    vm_sale_next = 0;
    apply_inputs();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    abandon_log.delete();
    ab_cyc = -1;
    n_vm_pulse = 0;
    n_done = 0;
    n_reject = 0;
    last_change = 2'b00;
    last_done_ch = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) chq[i].delete();
    apply_inputs();
    tick();
    tick();
    rst = 1'b1;
    clear_logs();
  endtask

  initial begin
    int start;
    logic [1:0] code;
    rst = 1'b0;
    vm_out = 1'b0;
    vm_change = 2'b00;
    spur_en = 0;
    cyc = 0;
    model_reset();
    vm_reset();
    clear_logs();
    for (int i = 0; i < N; i++) chq[i].delete();
    // acks must stay low in reset even with a coin pending
    push(0, 2'b01);
    tick();
    tick();

    // three small coins from ch0, sale on the third
    rst = 1'b1;
    clear_logs();
    push(0, 2'b01);
    push(0, 2'b01);
    tick();
    repeat (14) tick();
    check("t1_vm_pulses", 32'(n_vm_pulse), 32'd3);
    check("t1_done_count", 32'(n_done), 32'd1);
    check("t1_done_ch", 32'(last_done_ch), 32'd0);
    push(0, 2'b01);
    push(1, 2'b01);
    tick();
    check("t1_rr_next", 32'(last_ack), 32'b0010);
    repeat (30) tick();

    // ch0 and ch2 together: ch0 holds the lock until its sale
    do_reset();
    push(0, 2'b01); push(0, 2'b01); push(0, 2'b01);
    push(2, 2'b01);
    repeat (20) tick();
    check("t2_grants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      check("t2_g0", 32'(grant_log[0]), 32'd0);
      check("t2_g2", 32'(grant_log[2]), 32'd0);
      check("t2_g3", 32'(grant_log[3]), 32'd2);
    end
    repeat (15) tick();

    // invalid coin in IDLE
    do_reset();
    push(1, 2'b11);
    repeat (5) tick();
    check("t3_rejects", 32'(n_reject), 32'd1);
    check("t3_vm_pulses", 32'(n_vm_pulse), 32'd0);

    // ch3 locks then idles into an abandon; ch1 follows
    do_reset();
    push(3, 2'b01);
    start = cyc;
    tick();
    push(1, 2'b01);
    repeat (12) tick();
    check("t4_abandons", 32'(abandon_log.size()), 32'd1);
    if (abandon_log.size() >= 1) check("t4_abandon_ch", 32'(abandon_log[0]), 32'd3);
    check("t4_abandon_cycle", 32'(ab_cyc - start), 32'd8);
    check("t4_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) check("t4_next_grant", 32'(grant_log[1]), 32'd1);
    repeat (15) tick();

    // two large coins give change 01
    do_reset();
    push(0, 2'b10); push(0, 2'b10);
    repeat (12) tick();
    check("t5_done_count", 32'(n_done), 32'd1);
    check("t5_change", 32'(last_change), 32'b01);

    // reset asserted during FEED
    do_reset();
    push(1, 2'b11);
    repeat (2) tick();
    push(2, 2'b01);
    tick();
    @(negedge clk);
    check("t6_feed_vm_in", 32'(vm_in), 32'b01);
    rst = 1'b0;
    #1;
    check("t6_async_vm_in", 32'(vm_in), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_ack", 32'(ch_ack), 32'd0);
    model_reset();
    vm_reset();
    cyc++;
    @(posedge clk);
    #1;
    push(3, 2'b01);
    push(0, 2'b01);
    repeat (2) tick();
    rst = 1'b1;
    clear_logs();
    tick();
    check("t6_restart_ch0", 32'(last_ack), 32'b0001);
    repeat (30) tick();
    check("t6_no_abandon_from_reset", 32'(n_done + abandon_log.size() > 0), 32'd1);

    // randomized traffic with spurious vm_out outside SETTLE
    do_reset();
    spur_en = 1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int ch;
        ch = $urandom_range(0, N - 1);
        if ($urandom_range(0, 9) < 8) code = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        else code = $urandom_range(0, 1) ? 2'b00 : 2'b11;
        if (chq[ch].size() < 3) push(ch, code);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vend_coin_arbiter.md
# vend_coin_arbiter

Round-robin arbiter and session sequencer that shares one `vending_machine` coin input between N independent coin acceptors. It grants one acceptor at a time and locks the machine to that acceptor for the whole purchase. The lock holds until the machine reports a sale or the session times out. The block sits between the coin-acceptor front ends and the `vending_machine` instance, driving its `in` port and observing its `out`/`change` ports.

## Interface
- `N_CH`, default 4: number of coin acceptors (2..8).
- `TIMEOUT`, default 255: idle cycles in a locked session before it is abandoned (1..2^CNT_W-1).
- `CNT_W`, default 8: timeout counter width.
- `CH_W`, default 2: channel index width, must be ≥ clog2(N_CH).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ch_req`  in  N_CH  channel i has a coin pending; held until acked.
- `ch_coin`  in  2*N_CH  coin code of channel i at [2i+1:2i]: 01 = small, 10 = large, 00/11 = invalid.
- `ch_ack`  out  N_CH  one-hot, combinational; coin of channel i is consumed this cycle.
- `vm_in`  out  2  coin to the vending machine; non-zero for exactly one cycle per coin.
- `vm_out`  in  1  vending machine sale indication.
- `vm_change`  in  2  vending machine change code, valid with `vm_out`.
- `owner`  out  CH_W  channel currently holding the lock (0 when idle).
- `busy`  out  1  lock held (any state except IDLE).
- `reject`  out  1  one-cycle pulse: an invalid coin was acked and discarded.
- `done_valid`  out  1  one-cycle pulse: sale completed for `done_ch`.
- `done_ch`  out  CH_W  channel that completed or abandoned; valid with `done_valid`/`abandon`.
- `done_change`  out  2  `vm_change` captured at the sale.
- `abandon`  out  1  one-cycle pulse: locked session timed out.

## Operation
- FSM states: IDLE, FEED, SETTLE, HOLD.
- IDLE:
  - Round-robin over `ch_req`, starting at pointer `rr`. The winner w gets `ch_ack[w]` in the same cycle.
  - Valid coin: latch the coin, set `owner`=w, go to FEED.
  - Invalid coin: pulse `reject`, stay in IDLE, set `rr`=w+1 (mod N_CH).
- FEED: drive `vm_in` = latched coin for one cycle, then go to SETTLE.
- SETTLE: `vm_in`=00; sample `vm_out`.
  - `vm_out`=1: register `done_valid`, `done_ch`=owner, `done_change`=`vm_change`; set `rr`=owner+1; go to IDLE.
  - `vm_out`=0: clear the timer, go to HOLD.
- HOLD: only `ch_req[owner]` is considered; other channels are never acked while locked.
  - Owner valid coin: ack, latch, go to FEED.
  - Owner invalid coin: ack, pulse `reject`, stay in HOLD; the timer is not cleared.
  - Timer increments each HOLD cycle with no valid owner coin. On reaching TIMEOUT: pulse `abandon`, `done_ch`=owner, `rr`=owner+1, go to IDLE. Accumulated credit stays inside the vending machine; handling it is the system's responsibility.
- Timeout and a valid owner coin in the same cycle: the coin wins, and the session continues.
- `vm_out` asserted outside SETTLE is ignored.
- At most one `ch_ack` bit is high in any cycle; `ch_ack` is 0 in FEED and SETTLE.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE, `rr`=0, timer 0, `owner`=0. `vm_in`, `busy`, `reject`, `done_valid`, `done_ch`, `done_change`, and `abandon` are all 0. `ch_ack`=0 while in reset.
- Reset mid-session: the lock is dropped immediately, with no `done_valid` or `abandon` pulse.
- Coin acked at cycle t:
  - `vm_in` non-zero at t+1.
  - `vm_out` sampled at t+2.
  - `done_valid` high at t+3.
  - Earliest next ack at t+3.
- `busy` is registered: high from t+1 after the first valid ack until the cycle `done_valid`/`abandon` is high, inclusive. `busy`=0 the cycle after.
- Abandon: `abandon` high TIMEOUT+1 cycles after entering HOLD, provided no valid owner coin arrived.
- `reject`, `done_valid`, and `abandon` are mutually exclusive and registered (one cycle after the cause).

## Test plan
- Reset, then ch0 feeds 01, 01, 01; the machine raises `vm_out` on the third -> `vm_in` = 01 for 3 isolated single cycles, one `done_valid` with `done_ch`=0, `busy` falls after it, `rr`=1.
- ch0 and ch2 request together from reset, both with 01 -> ch0 granted and locked. ch2 is never acked until ch0's `done_valid`, then ch2 is granted next.
- ch1 coin 11 in IDLE -> `ch_ack[1]` pulses, `reject` pulses, `vm_in` stays 00, `busy` stays 0.
- Locked ch3, one coin, then idle with TIMEOUT=4 -> `abandon` pulses exactly 5 cycles after entering HOLD, `done_ch`=3; the other pending channel is granted next.
- ch0 10 then 10; machine returns `vm_out`=1 with `vm_change`=01 -> `done_change`=01 captured.
- Assert `rst` low during FEED -> `vm_in`, `busy`, and `ch_ack` go to 0 immediately. After release, no `done_valid`/`abandon` pulse, and arbitration restarts at ch0.
